// File: rtl/crossbar_2x2_sched.sv
// Two-input, two-output crossbar with one-entry input holds, registered outputs,
// per-output round-robin arbitration and a saturating contention counter.
module crossbar_2x2_sched #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    input  logic          in1_dest,
    output logic          in1_ready,
    input  logic          in2_valid,
    input  logic [DW-1:0] in2_data,
    input  logic          in2_dest,
    output logic          in2_ready,
    output logic          out1_valid,
    output logic [DW-1:0] out1_data,
    output logic          out1_src,
    input  logic          out1_ready,
    output logic          out2_valid,
    output logic [DW-1:0] out2_data,
    output logic          out2_src,
    input  logic          out2_ready,
    output logic [7:0]    conflicts
);

    logic [1:0]    in_valid;
    logic [1:0]    in_dest;
    logic [1:0]    in_ready;
    logic [1:0]    out_ready;
    logic [DW-1:0] in_data [2];

    logic [1:0]    hold_full_reg;
    logic [1:0]    hold_dest_reg;
    logic [DW-1:0] hold_data_reg [2];

    logic [1:0]    out_valid_reg;
    logic [1:0]    out_src_reg;
    logic [DW-1:0] out_data_reg [2];
    logic [1:0]    ptr_reg;
    logic [7:0]    conflicts_reg;

    logic [1:0]    req [2];
    logic [1:0]    free;
    logic [1:0]    contend;
    logic [1:0]    grant;
    logic [1:0]    win;
    logic [1:0]    gnt_in;

    assign in_valid   = {in2_valid, in1_valid};
    assign in_dest    = {in2_dest, in1_dest};
    assign out_ready  = {out2_ready, out1_ready};
    assign in_data[0] = in1_data;
    assign in_data[1] = in2_data;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_arb
            localparam logic SEL = (gi == 1);
            assign req[gi]     = {hold_full_reg[1] && (hold_dest_reg[1] == SEL),
                                  hold_full_reg[0] && (hold_dest_reg[0] == SEL)};
            assign free[gi]    = !out_valid_reg[gi] || out_ready[gi];
            assign contend[gi] = &req[gi];
            assign grant[gi]   = free[gi] && (|req[gi]);
            // Pointer only matters under contention; otherwise the lone requester wins.
            assign win[gi]     = contend[gi] ? ptr_reg[gi] : req[gi][1];
        end

        for (gi = 0; gi < 2; gi++) begin : g_in
            localparam logic SEL = (gi == 1);
            assign gnt_in[gi]   = (grant[0] && (win[0] == SEL)) ||
                                  (grant[1] && (win[1] == SEL));
            assign in_ready[gi] = !hold_full_reg[gi] || gnt_in[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full_reg <= 2'b00;
            hold_dest_reg <= 2'b00;
            out_valid_reg <= 2'b00;
            out_src_reg   <= 2'b00;
            ptr_reg       <= 2'b00;
            conflicts_reg <= 8'd0;
            for (int i = 0; i < 2; i++) begin
                hold_data_reg[i] <= '0;
                out_data_reg[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                // A refill at the same edge as the grant keeps the hold full.
                if (in_valid[i] && in_ready[i]) begin
                    hold_full_reg[i] <= 1'b1;
                    hold_data_reg[i] <= in_data[i];
                    hold_dest_reg[i] <= in_dest[i];
                end else if (gnt_in[i]) begin
                    hold_full_reg[i] <= 1'b0;
                end

                if (grant[i]) begin
                    out_valid_reg[i] <= 1'b1;
                    out_src_reg[i]   <= win[i];
                    out_data_reg[i]  <= win[i] ? hold_data_reg[1] : hold_data_reg[0];
                    if (contend[i])
                        ptr_reg[i] <= ~win[i];
                end else if (out_ready[i]) begin
                    out_valid_reg[i] <= 1'b0;
                end
            end

            if ((|contend) && (conflicts_reg != 8'hFF))
                conflicts_reg <= conflicts_reg + 8'd1;
        end
    end

    assign in1_ready  = in_ready[0];
    assign in2_ready  = in_ready[1];
    assign out1_valid = out_valid_reg[0];
    assign out1_data  = out_data_reg[0];
    assign out1_src   = out_src_reg[0];
    assign out2_valid = out_valid_reg[1];
    assign out2_data  = out_data_reg[1];
    assign out2_src   = out_src_reg[1];
    assign conflicts  = conflicts_reg;

endmodule

// File: tb/tb_crossbar_2x2_sched.sv
// Bench for crossbar_2x2_sched: vector table, hand-written contention/stall/reset
// sequences, and a per-(input,output) scoreboard fed by an edge monitor.
module tb_crossbar_2x2_sched;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in1_valid, in1_dest, in1_ready;
    logic [DW-1:0] in1_data;
    logic          in2_valid, in2_dest, in2_ready;
    logic [DW-1:0] in2_data;
    logic          out1_valid, out1_src, out1_ready;
    logic [DW-1:0] out1_data;
    logic          out2_valid, out2_src, out2_ready;
    logic [DW-1:0] out2_data;
    logic [7:0]    conflicts;

    crossbar_2x2_sched #(.DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in1_valid(in1_valid), .in1_data(in1_data), .in1_dest(in1_dest), .in1_ready(in1_ready),
        .in2_valid(in2_valid), .in2_data(in2_data), .in2_dest(in2_dest), .in2_ready(in2_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_src(out1_src), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_src(out2_src), .out2_ready(out2_ready),
        .conflicts(conflicts)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_conf = 0;
    int in1_acc  = 0;
    bit sb_en    = 1'b0;

    // Queues indexed by input*2 + output.
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    logic [DW-1:0] q2 [$];
    logic [DW-1:0] q3 [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic sb_push(input int idx, input logic [DW-1:0] d);
        case (idx)
            0: q0.push_back(d);
            1: q1.push_back(d);
            2: q2.push_back(d);
            default: q3.push_back(d);
        endcase
    endtask

    task automatic sb_pop(input int idx, input logic [DW-1:0] d, input string nm);
        int sz;
        logic [DW-1:0] e;
        case (idx)
            0: sz = q0.size();
            1: sz = q1.size();
            2: sz = q2.size();
            default: sz = q3.size();
        endcase
        if (sz == 0) begin
            check({nm, "_unexpected_word"}, 32'(d), 32'hFFFF_FFFF);
        end else begin
            case (idx)
                0: e = q0.pop_front();
                1: e = q1.pop_front();
                2: e = q2.pop_front();
                default: e = q3.pop_front();
            endcase
            check(nm, 32'(d), 32'(e));
        end
    endtask

    // Inputs change 1 time unit after posedge, so values here are those seen at the next edge.
    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (in1_valid && in1_ready) begin
                sb_push(in1_dest ? 1 : 0, in1_data);
                in1_acc++;
            end
            if (in2_valid && in2_ready)
                sb_push(in2_dest ? 3 : 2, in2_data);
            if (out1_valid && out1_ready)
                sb_pop(out1_src ? 2 : 0, out1_data, "sb_out1");
            if (out2_valid && out2_ready)
                sb_pop(out2_src ? 3 : 1, out2_data, "sb_out2");
        end
    end

    typedef struct {
        logic          v1;
        logic [DW-1:0] d1;
        logic          t1;
        logic          v2;
        logic [DW-1:0] d2;
        logic          t2;
        logic          ev1;
        logic [DW-1:0] ed1;
        logic          es1;
        logic          ev2;
        logic [DW-1:0] ed2;
        logic          es2;
        int            conf_inc;
    } vec_t;

    vec_t tbl [5];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in1_valid = 1'b0; in1_data = '0; in1_dest = 1'b0;
        in2_valid = 1'b0; in2_data = '0; in2_dest = 1'b0;
    endtask

    // Contention on out1: word a from in1, b from in2; w is the expected first winner.
    task automatic contend_out1(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic w, input string nm);
        step();
        in1_valid = 1'b1; in1_data = a; in1_dest = 1'b0;
        in2_valid = 1'b1; in2_data = b; in2_dest = 1'b0;
        step();
        idle_inputs();
        check({nm, "_in1_ready_loser"}, 32'(in1_ready), 32'(w == 1'b0));
        check({nm, "_in2_ready_loser"}, 32'(in2_ready), 32'(w == 1'b1));
        exp_conf++;
        step();
        check({nm, "_first_valid"}, 32'(out1_valid), 32'd1);
        check({nm, "_first_data"}, 32'(out1_data), 32'(w ? b : a));
        check({nm, "_first_src"}, 32'(out1_src), 32'(w));
        check({nm, "_conflicts"}, 32'(conflicts), 32'(exp_conf));
        step();
        check({nm, "_second_data"}, 32'(out1_data), 32'(w ? a : b));
        check({nm, "_second_src"}, 32'(out1_src), 32'(!w));
        step();
    endtask

    initial begin
        tbl[0] = '{1'b1, 4'h1, 1'b0, 1'b1, 4'h4, 1'b1, 1'b1, 4'h1, 1'b0, 1'b1, 4'h4, 1'b1, 0};
        tbl[1] = '{1'b1, 4'hA, 1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b1, 1'b1, 4'hA, 1'b0, 0};
        tbl[2] = '{1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'h2, 1'b0, 0};
        tbl[3] = '{1'b0, 4'h0, 1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 0};
        tbl[4] = '{1'b1, 4'h8, 1'b1, 1'b1, 4'h9, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'h8, 1'b0, 1};

        rst = 1'b1;
        idle_inputs();
        out1_ready = 1'b1;
        out2_ready = 1'b1;
        #1;
        check("rst_out1_valid", 32'(out1_valid), 32'd0);
        check("rst_out2_valid", 32'(out2_valid), 32'd0);
        check("rst_conflicts", 32'(conflicts), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out1_data", 32'(out1_data), 32'd0);
        check("rst_out2_src", 32'(out2_src), 32'd0);
        rst = 1'b0;
        sb_en = 1'b1;
        #1;
        check("post_rst_in1_ready", 32'(in1_ready), 32'd1);
        check("post_rst_in2_ready", 32'(in2_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("vec%0d_in1_ready", i), 32'(in1_ready), 32'd1);
            check($sformatf("vec%0d_in2_ready", i), 32'(in2_ready), 32'd1);
            in1_valid = tbl[i].v1; in1_data = tbl[i].d1; in1_dest = tbl[i].t1;
            in2_valid = tbl[i].v2; in2_data = tbl[i].d2; in2_dest = tbl[i].t2;
            step();
            idle_inputs();
            exp_conf += tbl[i].conf_inc;
            step();
            check($sformatf("vec%0d_out1_valid", i), 32'(out1_valid), 32'(tbl[i].ev1));
            if (tbl[i].ev1) begin
                check($sformatf("vec%0d_out1_data", i), 32'(out1_data), 32'(tbl[i].ed1));
                check($sformatf("vec%0d_out1_src", i), 32'(out1_src), 32'(tbl[i].es1));
            end
            check($sformatf("vec%0d_out2_valid", i), 32'(out2_valid), 32'(tbl[i].ev2));
            if (tbl[i].ev2) begin
                check($sformatf("vec%0d_out2_data", i), 32'(out2_data), 32'(tbl[i].ed2));
                check($sformatf("vec%0d_out2_src", i), 32'(out2_src), 32'(tbl[i].es2));
            end
            check($sformatf("vec%0d_conflicts", i), 32'(conflicts), 32'(exp_conf));
            repeat (3) @(posedge clk);
        end

        // Round-robin on out1: in1 first, then alternating.
        contend_out1(4'h3, 4'h7, 1'b0, "rr1");
        contend_out1(4'h3, 4'h7, 1'b1, "rr2");
        contend_out1(4'h3, 4'h7, 1'b0, "rr3");

        // Stalled output with in1 streaming 1,2,3.
        step();
        out1_ready = 1'b0;
        in1_acc = 0;
        in1_valid = 1'b1; in1_data = 4'h1; in1_dest = 1'b0;
        check("stall_ready_w1", 32'(in1_ready), 32'd1);
        step();
        in1_data = 4'h2;
        check("stall_ready_w2", 32'(in1_ready), 32'd1);
        step();
        in1_data = 4'h3;
        check("stall_out1_valid", 32'(out1_valid), 32'd1);
        check("stall_out1_data", 32'(out1_data), 32'h1);
        check("stall_ready_w3", 32'(in1_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("stall_hold%0d_data", k), 32'(out1_data), 32'h1);
            check($sformatf("stall_hold%0d_ready", k), 32'(in1_ready), 32'd0);
        end
        check("stall_accepted", 32'(in1_acc), 32'd2);
        out1_ready = 1'b1;
        step();
        idle_inputs();
        check("release_d2", 32'(out1_data), 32'h2);
        step();
        check("release_d3", 32'(out1_data), 32'h3);
        step();
        check("release_idle", 32'(out1_valid), 32'd0);
        repeat (2) @(posedge clk);

        // Saturation under a permanent stall, then async reset between edges.
        step();
        out1_ready = 1'b0;
        in1_valid = 1'b1; in1_data = 4'h9; in1_dest = 1'b0;
        in2_valid = 1'b1; in2_data = 4'h6; in2_dest = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("sat_conflicts", 32'(conflicts), 32'd255);
        check("sat_in1_ready", 32'(in1_ready), 32'd0);
        check("sat_in2_ready", 32'(in2_ready), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out1_valid", 32'(out1_valid), 32'd0);
        check("arst_out2_valid", 32'(out2_valid), 32'd0);
        check("arst_in1_ready", 32'(in1_ready), 32'd1);
        check("arst_in2_ready", 32'(in2_ready), 32'd1);
        check("arst_conflicts", 32'(conflicts), 32'd0);
        check("arst_out1_data", 32'(out1_data), 32'd0);
        #1;
        rst = 1'b0;
        idle_inputs();
        out1_ready = 1'b1;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();

        // One clean transfer after reset, checked through the scoreboard.
        step();
        in1_valid = 1'b1; in1_data = 4'hE; in1_dest = 1'b1;
        step();
        idle_inputs();
        step();
        check("post_arst_out2_data", 32'(out2_data), 32'hE);
        repeat (3) @(posedge clk);
        #1;
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);
        check("drain_q2", 32'(q2.size()), 32'd0);
        check("drain_q3", 32'(q3.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crossbar_2x2_sched.md
CROSSBAR_2X2_SCHED -- requirements
Module: crossbar_2x2_sched

Interface
REQ-001 Parameter DW, default 4, payload width in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in1_valid  input  1  input 1 offers a word.
REQ-005 in1_data  input  DW  input 1 payload.
REQ-006 in1_dest  input  1  input 1 destination: 0 = out1, 1 = out2.
REQ-007 in1_ready  output  1  input 1 can accept a word.
REQ-008 in2_valid, in2_data, in2_dest, in2_ready: same directions, widths and meanings as the in1 ports, for input 2.
REQ-009 out1_valid  output  1  out1 holds a word.
REQ-010 out1_data  output  DW  out1 payload.
REQ-011 out1_src  output  1  source of the out1 word: 0 = in1, 1 = in2.
REQ-012 out1_ready  input  1  sink accepts the out1 word.
REQ-013 out2_valid, out2_data, out2_src, out2_ready: same directions, widths and meanings as the out1 ports, for out2.
REQ-014 conflicts  output  8  saturating count of contended cycles.

Function
REQ-015 Each input SHALL have a one-entry hold register (data, dest, full flag).
REQ-016 An input transfer SHALL occur when inX_valid && inX_ready at the clk edge.
REQ-017 The transfer SHALL load the hold register and set its full flag.
REQ-018 Each output SHALL have a one-entry output register.
REQ-019 An output register is free in a cycle when outY_valid==0 or outY_ready==1.
REQ-020 An output handshake completes when outY_valid && outY_ready at the edge.
REQ-021 Per output, a request exists from each full hold register whose dest selects that output.
REQ-022 A grant SHALL be issued only when the target output register is free.
REQ-023 With a single request, that requester SHALL be granted.
REQ-024 With two requests to the same output, the per-output round-robin pointer SHALL pick the winner.
REQ-025 After a contended grant, that output's pointer SHALL move to the losing input.
REQ-026 Uncontended grants SHALL leave the pointer unchanged.
REQ-027 Both outputs SHALL be granted in the same cycle when the dests differ (straight or crossed).
REQ-028 On a grant, the winning hold word SHALL load into the output register.
REQ-029 On a grant, outY_src SHALL record the winning input.
REQ-030 On a grant, outY_valid SHALL be set.
REQ-031 The granted hold register SHALL clear at the same edge unless refilled at that edge.
REQ-032 An output with no grant at a handshake edge SHALL drop outY_valid.
REQ-033 An output stalled (valid && !ready) SHALL keep data, src and valid stable.
REQ-034 inX_ready SHALL be (hold empty) OR (hold granted this cycle); it is combinational from out*_ready.
REQ-035 Latency: a word accepted at edge N SHALL appear with outY_valid=1 after edge N+1 when uncontended and the output is free.
REQ-036 Sustained throughput SHALL be one word per cycle per input when uncontended.
REQ-037 A losing input SHALL hold its word with inX_ready=0 until granted.
REQ-038 No word SHALL be dropped, duplicated or reordered per input/output pair.
REQ-039 conflicts SHALL increment by 1 per cycle in which both holds request the same output.
REQ-040 conflicts SHALL increment regardless of grant and SHALL saturate at 255 with no wrap.
REQ-041 outY_data and outY_src SHALL change only on a grant.

Reset
REQ-042 While rst=1, both hold full flags SHALL be 0.
REQ-043 While rst=1, out1_valid and out2_valid SHALL be 0.
REQ-044 While rst=1, out*_data and out*_src SHALL be 0.
REQ-045 While rst=1, conflicts SHALL be 0.
REQ-046 While rst=1, both round-robin pointers SHALL select in1.
REQ-047 These values SHALL apply immediately on rst rising, independent of clk.
REQ-048 Reset asserted mid-operation SHALL discard all held and in-flight words.
REQ-049 in1_ready and in2_ready SHALL be 1 once rst deasserts.

Verification
REQ-050 Scenario 1: in1=4'h1 dest0 and in2=4'h4 dest1 in the same cycle, outputs ready -> next cycle out1=1 (src0) and out2=4 (src1); conflicts stays 0.
REQ-051 Scenario 2: in1=4'hA dest1 and in2=4'h5 dest0 -> out2=A (src0) and out1=5 (src1) together (crossed).
REQ-052 Scenario 3: both inputs dest0 with 4'h3 and 4'h7, out1_ready=1 -> out1 shows 3 then 7 on consecutive cycles; in2_ready=0 for one cycle; conflicts=1; out1 pointer ends at in2.
REQ-053 Scenario 4: repeat the scenario-3 contention -> in2 wins first; the winner alternates on each further contention.
REQ-054 Scenario 5: out1_ready=0 while in1 streams 1,2,3 to dest0 -> out1 holds 1 stable; in1 accepts exactly 2 words then ready=0; on release, out1 delivers 1,2,3 in order.
REQ-055 Scenario 6: 300 contended cycles -> conflicts=255; rst pulse mid-stall -> all out_valid=0, readies=1, conflicts=0 with no clk edge.
